// File: rtl/rggen_axi4lite_bridge_pkg.sv
// Shared definitions for the rggen-to-AXI4-Lite bridge: FSM states, access and response codes.
package rggen_axi4lite_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitResp,
    StDone
  } state_e;

  localparam logic [1:0] RGGEN_READ = 2'b10;
  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

endpackage

// File: rtl/rggen_axi4lite_channel_valid.sv
// Per-channel valid/done tracker: valid rises on start, falls on its own handshake.
module rggen_axi4lite_channel_valid (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_enable,
  input  logic i_ready,
  output logic o_valid,
  output logic o_done
);

  logic valid_q;
  logic done_q;

  // A channel not used by this access reports done immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (i_start) begin
      valid_q <= i_enable;
      done_q  <= !i_enable;
    end else if (valid_q && i_ready) begin
      valid_q <= 1'b0;
      done_q  <= 1'b1;
    end
  end

  assign o_valid = valid_q;
  assign o_done  = done_q | (valid_q & i_ready);

endmodule

// File: rtl/rggen_axi4lite_bridge_pipelined.sv
// rggen bus to AXI4-Lite master bridge, one outstanding transaction.
// Define RGGEN_AXI4LITE_BRIDGE_ID_CHECK_EN to flag responses whose ID differs from the issued one.
module rggen_axi4lite_bridge_pipelined
  import rggen_axi4lite_bridge_pkg::*;
#(
  parameter int          ID_WIDTH      = 0,
  parameter int          ADDRESS_WIDTH = 8,
  parameter int          BUS_WIDTH     = 32,
  parameter logic [2:0]  PROT          = 3'b000
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_bus_valid,
  input  logic [1:0]                             i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0]               i_bus_address,
  input  logic [BUS_WIDTH-1:0]                   i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]                 i_bus_strobe,
  output logic                                   o_bus_ready,
  output logic [1:0]                             o_bus_status,
  output logic [BUS_WIDTH-1:0]                   o_bus_read_data,
  output logic                                   o_awvalid,
  input  logic                                   i_awready,
  output logic [(ID_WIDTH > 0 ? ID_WIDTH : 1)-1:0] o_awid,
  output logic [ADDRESS_WIDTH-1:0]               o_awaddr,
  output logic [2:0]                             o_awprot,
  output logic                                   o_wvalid,
  input  logic                                   i_wready,
  output logic [BUS_WIDTH-1:0]                   o_wdata,
  output logic [BUS_WIDTH/8-1:0]                 o_wstrb,
  input  logic                                   i_bvalid,
  output logic                                   o_bready,
  input  logic [(ID_WIDTH > 0 ? ID_WIDTH : 1)-1:0] i_bid,
  input  logic [1:0]                             i_bresp,
  output logic                                   o_arvalid,
  input  logic                                   i_arready,
  output logic [(ID_WIDTH > 0 ? ID_WIDTH : 1)-1:0] o_arid,
  output logic [ADDRESS_WIDTH-1:0]               o_araddr,
  output logic [2:0]                             o_arprot,
  input  logic                                   i_rvalid,
  output logic                                   o_rready,
  input  logic [(ID_WIDTH > 0 ? ID_WIDTH : 1)-1:0] i_rid,
  input  logic [1:0]                             i_rresp,
  input  logic [BUS_WIDTH-1:0]                   i_rdata
);

  localparam int IdBits = (ID_WIDTH > 0) ? ID_WIDTH : 1;

  state_e                   state_q, state_d;
  logic [1:0]               access_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [BUS_WIDTH/8-1:0]   strobe_q;
  logic [IdBits-1:0]        id_q;
  logic [1:0]               status_q;
  logic [BUS_WIDTH-1:0]     read_data_q;

  logic       start;
  logic       start_write;
  logic       is_read;
  logic       aw_done;
  logic       w_done;
  logic       ar_done;
  logic       resp_hs;
  logic [1:0] resp;
  logic       id_error;

  assign start       = (state_q == StIdle) && i_bus_valid;
  assign start_write = (i_bus_access != RGGEN_READ);
  assign is_read     = (access_q == RGGEN_READ);
  assign resp_hs     = (state_q == StWaitResp) && (is_read ? i_rvalid : i_bvalid);
  assign resp        = is_read ? i_rresp : i_bresp;

`ifdef RGGEN_AXI4LITE_BRIDGE_ID_CHECK_EN
  logic [IdBits-1:0] resp_id;
  assign resp_id  = is_read ? i_rid : i_bid;
  assign id_error = (ID_WIDTH > 0) && (resp_id != id_q);
`else
  logic unused_resp_id;
  assign unused_resp_id = ^{i_bid, i_rid};
  assign id_error       = 1'b0;
`endif

  rggen_axi4lite_channel_valid u_aw (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (start),
    .i_enable (start_write),
    .i_ready  (i_awready),
    .o_valid  (o_awvalid),
    .o_done   (aw_done)
  );

  rggen_axi4lite_channel_valid u_w (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (start),
    .i_enable (start_write),
    .i_ready  (i_wready),
    .o_valid  (o_wvalid),
    .o_done   (w_done)
  );

  rggen_axi4lite_channel_valid u_ar (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (start),
    .i_enable (!start_write),
    .i_ready  (i_arready),
    .o_valid  (o_arvalid),
    .o_done   (ar_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (i_bus_valid) state_d = StIssue;
      StIssue:    if (is_read ? ar_done : (aw_done && w_done)) state_d = StWaitResp;
      StWaitResp: if (resp_hs) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      access_q     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      id_q         <= '0;
      status_q     <= AXI_OKAY;
      read_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        access_q     <= i_bus_access;
        address_q    <= i_bus_address;
        write_data_q <= i_bus_write_data;
        strobe_q     <= i_bus_strobe;
      end
      if (resp_hs) begin
        status_q <= id_error ? AXI_SLVERR : resp;
        if (is_read) read_data_q <= id_error ? '0 : i_rdata;
        // Natural overflow gives the wrap at all-ones; a zero-width ID stays at 0.
        if (ID_WIDTH > 0) id_q <= id_q + 1'b1;
      end
    end
  end

  assign o_bus_ready     = (state_q == StDone);
  assign o_bus_status    = status_q;
  assign o_bus_read_data = read_data_q;

  assign o_awid   = id_q;
  assign o_awaddr = address_q;
  assign o_awprot = PROT;
  assign o_wdata  = write_data_q;
  assign o_wstrb  = strobe_q;
  assign o_arid   = id_q;
  assign o_araddr = address_q;
  assign o_arprot = PROT;
  assign o_bready = (state_q == StWaitResp) && !is_read;
  assign o_rready = (state_q == StWaitResp) && is_read;

endmodule

// File: tb/tb_rggen_axi4lite_bridge_pipelined.sv
// Self-checking bench: directed and random transactions against a cycle-count/ID reference model.
module tb_rggen_axi4lite_bridge_pipelined;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_bus_valid = 1'b0;
  logic [1:0]  i_bus_access = '0;
  logic [7:0]  i_bus_address = '0;
  logic [31:0] i_bus_write_data = '0;
  logic [3:0]  i_bus_strobe = '0;
  logic        o_bus_ready;
  logic [1:0]  o_bus_status;
  logic [31:0] o_bus_read_data;
  logic        o_awvalid, i_awready = 1'b0;
  logic [1:0]  o_awid;
  logic [7:0]  o_awaddr;
  logic [2:0]  o_awprot;
  logic        o_wvalid, i_wready = 1'b0;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        i_bvalid = 1'b0, o_bready;
  logic [1:0]  i_bid = '0, i_bresp = '0;
  logic        o_arvalid, i_arready = 1'b0;
  logic [1:0]  o_arid;
  logic [7:0]  o_araddr;
  logic [2:0]  o_arprot;
  logic        i_rvalid = 1'b0, o_rready;
  logic [1:0]  i_rid = '0, i_rresp = '0;
  logic [31:0] i_rdata = '0;

  always #5 i_clk = ~i_clk;

  rggen_axi4lite_bridge_pipelined #(
    .ID_WIDTH      (2),
    .ADDRESS_WIDTH (8),
    .BUS_WIDTH     (32),
    .PROT          (3'b010)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_bus_valid      (i_bus_valid),
    .i_bus_access     (i_bus_access),
    .i_bus_address    (i_bus_address),
    .i_bus_write_data (i_bus_write_data),
    .i_bus_strobe     (i_bus_strobe),
    .o_bus_ready      (o_bus_ready),
    .o_bus_status     (o_bus_status),
    .o_bus_read_data  (o_bus_read_data),
    .o_awvalid        (o_awvalid),
    .i_awready        (i_awready),
    .o_awid           (o_awid),
    .o_awaddr         (o_awaddr),
    .o_awprot         (o_awprot),
    .o_wvalid         (o_wvalid),
    .i_wready         (i_wready),
    .o_wdata          (o_wdata),
    .o_wstrb          (o_wstrb),
    .i_bvalid         (i_bvalid),
    .o_bready         (o_bready),
    .i_bid            (i_bid),
    .i_bresp          (i_bresp),
    .o_arvalid        (o_arvalid),
    .i_arready        (i_arready),
    .o_arid           (o_arid),
    .o_araddr         (o_araddr),
    .o_arprot         (o_arprot),
    .i_rvalid         (i_rvalid),
    .o_rready         (o_rready),
    .i_rid            (i_rid),
    .i_rresp          (i_rresp),
    .i_rdata          (i_rdata)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          id_model = 0;
  logic [31:0] rd_model = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    i_awready = 1'b0; i_wready = 1'b0; i_arready = 1'b0;
    i_bvalid = 1'b0; i_rvalid = 1'b0;
    i_bresp = '0; i_rresp = '0; i_bid = '0; i_rid = '0; i_rdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valids"}, {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_bus_ready}, 0);
    check({tag, "_status"}, o_bus_status, 2'b00);
    check({tag, "_rdata"}, o_bus_read_data, 0);
    check({tag, "_ids"}, {o_awid, o_arid}, 0);
    check({tag, "_req"}, {o_awaddr, o_araddr, o_wdata, o_wstrb}, 0);
  endtask

  // One complete bus transaction with the bench acting as a delaying AXI slave.
  task automatic run_txn(input bit rd, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int aw_dly, input int w_dly,
                         input int ar_dly, input int resp_dly, input logic [1:0] resp,
                         input logic [31:0] rdata, input bit bad_id);
    int          cyc = 0;
    int          done_cyc = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0, resp_hs = 0;
    int          exp_cyc;
    bit          done = 1'b0;
    logic [1:0]  exp_id;
    logic [1:0]  exp_status;
    logic [31:0] exp_rd;
    logic [1:0]  wacc;
    exp_id = id_model[1:0];
    wacc = 2'($urandom_range(0, 2));
    if (wacc == 2'b10) wacc = 2'b11;
    i_bus_valid      = 1'b1;
    i_bus_access     = rd ? 2'b10 : wacc;
    i_bus_address    = addr;
    i_bus_write_data = wdata;
    i_bus_strobe     = strb;
    while (!done && cyc < 60) begin
      @(negedge i_clk);
      cyc++;
      if (o_bus_ready) begin
        done = 1'b1;
        done_cyc = cyc;
      end else begin
        if (o_awvalid) begin
          aw_cnt++;
          i_awready = (aw_cnt > aw_dly);
          if (i_awready) begin
            aw_hs++;
            check("aw_fields", {o_awaddr, o_awid, o_awprot}, {addr, exp_id, 3'b010});
          end
        end else i_awready = 1'b0;
        if (o_wvalid) begin
          w_cnt++;
          i_wready = (w_cnt > w_dly);
          if (i_wready) begin
            w_hs++;
            check("w_fields", {o_wdata, o_wstrb}, {wdata, strb});
          end
        end else i_wready = 1'b0;
        if (o_arvalid) begin
          ar_cnt++;
          i_arready = (ar_cnt > ar_dly);
          if (i_arready) begin
            ar_hs++;
            check("ar_fields", {o_araddr, o_arid, o_arprot}, {addr, exp_id, 3'b010});
          end
        end else i_arready = 1'b0;
        if (o_bready || o_rready) begin
          r_cnt++;
          i_bresp = resp; i_rresp = resp; i_rdata = rdata;
          i_bid = bad_id ? ~exp_id : exp_id;
          i_rid = bad_id ? ~exp_id : exp_id;
          i_bvalid = o_bready && (r_cnt > resp_dly);
          i_rvalid = o_rready && (r_cnt > resp_dly);
          if (i_bvalid || i_rvalid) resp_hs++;
        end else begin
          i_bvalid = 1'b0;
          i_rvalid = 1'b0;
        end
      end
    end
    i_bus_valid = 1'b0;
    clear_slave();
    check("completed", done, 1'b1);
    exp_cyc = (rd ? ar_dly + 1 : ((aw_dly > w_dly) ? aw_dly : w_dly) + 1) + resp_dly + 2;
    check("latency", done_cyc, exp_cyc);
    if (rd) begin
      check("hs_counts", {8'(aw_hs), 8'(w_hs), 8'(ar_hs), 8'(resp_hs)}, {8'd0, 8'd0, 8'd1, 8'd1});
      check("ar_valid_cycles", ar_cnt, ar_dly + 1);
    end else begin
      check("hs_counts", {8'(aw_hs), 8'(w_hs), 8'(ar_hs), 8'(resp_hs)}, {8'd1, 8'd1, 8'd0, 8'd1});
      check("aw_valid_cycles", aw_cnt, aw_dly + 1);
      check("w_valid_cycles", w_cnt, w_dly + 1);
    end
    exp_status = resp;
    exp_rd = rd ? rdata : rd_model;
`ifdef RGGEN_AXI4LITE_BRIDGE_ID_CHECK_EN
    if (bad_id) begin
      exp_status = 2'b10;
      if (rd) exp_rd = '0;
    end
`endif
    check("bus_status", o_bus_status, exp_status);
    check("bus_read_data", o_bus_read_data, exp_rd);
    rd_model = exp_rd;
    id_model = (id_model + 1) % 4;
    @(negedge i_clk);
    check("ready_one_cycle", o_bus_ready, 1'b0);
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    i_bus_valid = 1'b0;
    clear_slave();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    id_model = 0;
    rd_model = '0;
  endtask

  initial begin
    int cnt;
    int pulses;
    apply_reset();
    @(negedge i_clk);
    check_reset_outputs("reset");

    // Plain write, zero-wait slave.
    run_txn(1'b0, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 1'b0);
    // AW accepted late, W immediately.
    run_txn(1'b0, 8'h14, 32'hCAFEF00D, 4'h3, 4, 0, 0, 0, 2'b00, 32'h0, 1'b0);
    // Read with SLVERR, then a write that must keep the read data.
    run_txn(1'b1, 8'h20, 32'h0, 4'h0, 0, 0, 0, 0, 2'b10, 32'h12345678, 1'b0);
    run_txn(1'b0, 8'h24, 32'h0BADBEEF, 4'hC, 0, 2, 0, 1, 2'b00, 32'hFFFF0000, 1'b0);

    // Five back-to-back reads from a fresh ID counter; first returns a wrong RID.
    apply_reset();
    run_txn(1'b1, 8'h30, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'hA5A5A5A5, 1'b1);
    for (int i = 0; i < 4; i++)
      run_txn(1'b1, 8'(8'h34 + 4 * i), 32'h0, 4'h0, 0, 0, i, 0, 2'b00, $urandom, 1'b0);

    for (int i = 0; i < 12; i++)
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 2'($urandom), $urandom, 1'($urandom_range(0, 3) == 0));

    // Reset while waiting for the write response.
    i_bus_valid = 1'b1; i_bus_access = 2'b01; i_bus_address = 8'h44;
    i_bus_write_data = 32'h11223344; i_bus_strobe = 4'hF;
    i_awready = 1'b1; i_wready = 1'b1;
    cnt = 0;
    while (!o_bready && cnt < 20) begin
      @(negedge i_clk);
      cnt++;
    end
    check("reached_wait_resp", o_bready, 1'b1);
    i_rst_n = 1'b0;
    i_bus_valid = 1'b0;
    clear_slave();
    @(negedge i_clk);
    check_reset_outputs("mid_reset");
    i_rst_n = 1'b1;
    id_model = 0;
    rd_model = '0;
    pulses = 0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_bus_ready) pulses++;
    end
    check("no_pulse_after_reset", pulses, 0);
    run_txn(1'b0, 8'h48, 32'h55667788, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
